// File: rtl/mul_int.sv
// Sequential unsigned shift-add multiplier (one multiplier bit per clock) with the
// same start/busy/valid handshake as div_int. Define MUL_INT_SAT_EN to saturate p on overflow.
module mul_int #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             valid,
  output logic             ovf,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] p_hi
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [W2-1:0]    a_sh, a_sh_nxt;
  logic [WIDTH-1:0] b_sh, b_sh_nxt;
  logic [W2-1:0]    acc, acc_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             busy_nxt, valid_nxt, ovf_nxt;
  logic [WIDTH-1:0] p_nxt, p_hi_nxt;

  logic [W2-1:0]    acc_add;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] p_fin;

  // Conditional partial-product add; acc is double width so no carry is lost.
  assign acc_add = b_sh[0] ? (acc + a_sh) : acc;
  assign acc_hi  = acc_add[W2-1:WIDTH];

`ifdef MUL_INT_SAT_EN
  assign p_fin = (|acc_hi) ? {WIDTH{1'b1}} : acc_add[WIDTH-1:0];
`else
  assign p_fin = acc_add[WIDTH-1:0];
`endif

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      valid <= 1'b0;
      ovf   <= 1'b0;
      p     <= '0;
      p_hi  <= '0;
    end else begin
      state <= state_nxt;
      a_sh  <= a_sh_nxt;
      b_sh  <= b_sh_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      busy  <= busy_nxt;
      valid <= valid_nxt;
      ovf   <= ovf_nxt;
      p     <= p_nxt;
      p_hi  <= p_hi_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    a_sh_nxt  = a_sh;
    b_sh_nxt  = b_sh;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    busy_nxt  = busy;
    valid_nxt = valid;
    ovf_nxt   = ovf;
    p_nxt     = p;
    p_hi_nxt  = p_hi;

    case (state)
      IDLE: begin
        if (start) begin
          if ((x == '0) || (y == '0)) begin
            // Zero operand: result known immediately, no CALC pass needed.
            valid_nxt = 1'b1;
            busy_nxt  = 1'b0;
            ovf_nxt   = 1'b0;
            p_nxt     = '0;
            p_hi_nxt  = '0;
          end else begin
            a_sh_nxt  = W2'(x);
            b_sh_nxt  = y;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            busy_nxt  = 1'b1;
            valid_nxt = 1'b0;
            ovf_nxt   = 1'b0;
            state_nxt = CALC;
          end
        end
      end
      CALC: begin
        acc_nxt  = acc_add;
        a_sh_nxt = a_sh << 1;
        b_sh_nxt = b_sh >> 1;
        cnt_nxt  = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          busy_nxt  = 1'b0;
          valid_nxt = 1'b1;
          p_hi_nxt  = acc_hi;
          ovf_nxt   = |acc_hi;
          p_nxt     = p_fin;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mul_int.sv
// Self-checking bench for mul_int (WIDTH=4): directed cases, protocol corners,
// async reset and randomized operands against an arithmetic reference model.
module tb_mul_int;

  localparam int unsigned WIDTH = 4;
  localparam int MASK = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] x, y;
  logic             busy, valid, ovf;
  logic [WIDTH-1:0] p, p_hi;

  int checks = 0;
  int failures = 0;

  mul_int #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
    .busy(busy), .valid(valid), .ovf(ovf), .p(p), .p_hi(p_hi)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: full product by plain multiplication, then split/saturate.
  function automatic void model(input int xv, input int yv,
                                output int ep, output int eph, output int eo);
    int prod;
    prod = xv * yv;
    eph  = (prod >> WIDTH) & MASK;
    ep   = prod & MASK;
    eo   = (eph != 0) ? 1 : 0;
`ifdef MUL_INT_SAT_EN
    if (eo != 0) ep = MASK;
`endif
  endfunction

  task automatic check_result(input string tag, input int xv, input int yv);
    int ep, eph, eo;
    model(xv, yv, ep, eph, eo);
    checks++;
    if (p !== WIDTH'(ep) || p_hi !== WIDTH'(eph) || ovf !== 1'(eo) || valid !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s x=%0d y=%0d: got p=%0d p_hi=%0d ovf=%0b valid=%0b busy=%0b, want p=%0d p_hi=%0d ovf=%0d valid=1 busy=0",
               tag, xv, yv, p, p_hi, ovf, valid, busy, ep, eph, eo);
    end
  endtask

  // Wait for valid with a bound; lat counts edges after the accepting edge.
  task automatic wait_valid(input string tag, output int lat, output bit held);
    logic [WIDTH-1:0] pp, ph;
    pp = p; ph = p_hi; held = 1'b1; lat = 0;
    while (valid !== 1'b1 && lat < 3 * WIDTH) begin
      if (busy !== 1'b1 || p !== pp || p_hi !== ph) held = 1'b0;
      x = WIDTH'($urandom);
      y = WIDTH'($urandom);
      tick();
      lat++;
    end
    checks++;
    if (valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_timeout: valid=%0b after %0d edges, want 1", tag, valid, lat);
    end
  endtask

  task automatic run_op(input string tag, input int xv, input int yv);
    int lat;
    bit held;
    x = WIDTH'(xv); y = WIDTH'(yv); start = 1'b1;
    tick();
    start = 1'b0;
    if (xv == 0 || yv == 0) begin
      check_result({tag, "_zero"}, xv, yv);
    end else begin
      checks++;
      if (valid !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL %s_accept: valid=%0b busy=%0b, want valid=0 busy=1", tag, valid, busy);
      end
      wait_valid(tag, lat, held);
      checks++;
      if (lat != WIDTH || !held) begin
        failures++;
        $display("FAIL %s_latency: lat=%0d busy/result held=%0b, want lat=%0d held=1", tag, lat, held, WIDTH);
      end
      check_result(tag, xv, yv);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; x = '0; y = '0;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || ovf !== 1'b0 || p !== '0 || p_hi !== '0) begin
      failures++;
      $display("FAIL reset_values: busy=%0b valid=%0b ovf=%0b p=%0d p_hi=%0d, want all 0",
               busy, valid, ovf, p, p_hi);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero();
    run_op("zero_x", 0, 5);
    run_op("zero_y", 9, 0);
  endtask

  task automatic test_directed();
    run_op("normal", 3, 5);
    run_op("overflow", 7, 3);
    run_op("maximum", 15, 15);
  endtask

  task automatic test_protocol();
    int lat;
    bit held;
    x = 2; y = 3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    x = 15; y = 15; start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid("protocol", lat, held);
    checks++;
    if (lat != WIDTH - 2) begin
      failures++;
      $display("FAIL protocol_latency: lat=%0d, want %0d", lat, WIDTH - 2);
    end
    check_result("protocol_ignored_start", 2, 3);
    run_op("protocol_next", 1, 1);
  endtask

  // start held high: accepted every WIDTH+1 edges, ignored on completion edge.
  task automatic test_back_to_back();
    int xv, yv, lat;
    bit held;
    xv = $urandom_range(1, MASK); yv = $urandom_range(1, MASK);
    x = WIDTH'(xv); y = WIDTH'(yv); start = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      wait_valid("b2b", lat, held);
      checks++;
      if (lat != WIDTH) begin
        failures++;
        $display("FAIL b2b_period: lat=%0d, want %0d", lat, WIDTH);
      end
      check_result("b2b", xv, yv);
      xv = $urandom_range(1, MASK); yv = $urandom_range(1, MASK);
      x = WIDTH'(xv); y = WIDTH'(yv);
      tick();
      checks++;
      if (valid !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL b2b_reaccept: valid=%0b busy=%0b, want valid=0 busy=1", valid, busy);
      end
    end
    start = 1'b0;
    wait_valid("b2b_last", lat, held);
    check_result("b2b_last", xv, yv);
  endtask

  task automatic test_async_reset();
    bit seen_valid;
    x = 13; y = 11; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || ovf !== 1'b0 || p !== '0 || p_hi !== '0) begin
      failures++;
      $display("FAIL async_reset: busy=%0b valid=%0b ovf=%0b p=%0d p_hi=%0d, want all 0",
               busy, valid, ovf, p, p_hi);
    end
    tick();
    #2 rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      tick();
      if (valid !== 1'b0 || busy !== 1'b0) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid) begin
      failures++;
      $display("FAIL async_reset_no_valid: activity seen after abort, want none");
    end
    run_op("after_reset", 2, 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_op("random", int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)));
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_directed();
    test_protocol();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
